// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word/address types and fetch-related constants.
// Used by fetch_stage, imem and the decode stage.
package mips_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  localparam word_t NOP_INST         = 32'h0000_0000;  // sll $0,$0,0
  localparam addr_t INST_BYTES       = 32'd4;
  localparam int    WORD_SHIFT       = 2;
  localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid flag.
// Priority is rst > flush > load; with none asserted the contents hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= inst_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (redirect > stall >
// sequential), imem word addressing and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic [31:0] fetch_count
);

  addr_t pc_next;
  addr_t pc_plus4;
  logic  load;

  assign pc_plus4  = pc + INST_BYTES;  // modulo 2^32: 0xFFFF_FFFC wraps to 0
  assign imem_addr = pc >> WORD_SHIFT;

  // A redirect squashes the wrong-path fetch, so only a clean edge loads IF/ID.
  assign load = !stall && !redirect_valid;

  // NOTE: pc_next is given a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      if (load) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flush   (redirect_valid),
    .inst_in (imem_inst),
    .pc4_in  (pc_plus4),
    .valid   (if_id_valid),
    .inst    (if_id_inst),
    .pc4     (if_id_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then random stall/redirect/reset traffic against a reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .pc              (pc),
    .if_id_valid     (if_id_valid),
    .if_id_inst      (if_id_inst),
    .if_id_pc4       (if_id_pc4),
    .fetch_count     (fetch_count)
  );

  // Instruction memory: a few preloaded cells, every other word a hash of its index.
  logic [31:0] mcell [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] widx);
    if (mcell.exists(widx)) return mcell[widx];
    return (widx * 32'h9E37_79B9) ^ 32'hA5A5_5A5A;
  endfunction

  always @(imem_addr) imem_inst = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural behaviour of the stage, one update per edge.
  logic [31:0] m_pc, m_inst, m_pc4, m_count;
  logic        m_valid;
  bit          live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
      live = 1'b1;
    end else if (live) begin
      if (redirect_valid) begin
        m_pc = redirect_target & ~32'h3;
        m_valid = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0;
      end else if (!stall) begin
        m_inst  = mem_word(m_pc / 4);
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc4;
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_pc",       pc,                 m_pc);
      check("model_imem",     imem_addr,          m_pc / 4);
      check("model_valid",    {31'd0, if_id_valid}, {31'd0, m_valid});
      check("model_inst",     if_id_inst,         m_inst);
      check("model_pc4",      if_id_pc4,          m_pc4);
      check("model_count",    fetch_count,        m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] tgt);
    rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
  endtask

  initial begin
    mcell[32'd0]  = 32'h2008_0005;
    mcell[32'd1]  = 32'h2009_0003;
    mcell[32'd10] = 32'h0109_5020;
    drive(1'b1, 1'b0, 1'b0, 32'h0);

    // 1: reset for two edges, then sequential fetch
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_inst", if_id_inst, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_imem", imem_addr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("t1_inst0", if_id_inst, 32'h2008_0005);
    check("t1_pc4_0", if_id_pc4, 32'd4);
    check("t1_cnt1", fetch_count, 32'd1);
    check("t1_imem1", imem_addr, 32'd1);
    step();
    check("t1_inst1", if_id_inst, 32'h2009_0003);
    check("t1_pc4_1", if_id_pc4, 32'd8);
    check("t1_cnt2", fetch_count, 32'd2);
    check("t1_imem2", imem_addr, 32'd2);

    // 2: stall three edges at pc=8
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_pc", pc, 32'd8);
      check("t2_imem", imem_addr, 32'd2);
      check("t2_inst", if_id_inst, 32'h2009_0003);
      check("t2_cnt", fetch_count, 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("t2_resume_pc", pc, 32'd12);
    check("t2_resume_cnt", fetch_count, 32'd3);

    // 3: redirect to 0x28
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0028);
    step();
    check("t3_pc", pc, 32'h28);
    check("t3_valid", {31'd0, if_id_valid}, 32'd0);
    check("t3_inst", if_id_inst, 32'h0);
    check("t3_cnt", fetch_count, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("t3_inst_tgt", if_id_inst, 32'h0109_5020);
    check("t3_pc4_tgt", if_id_pc4, 32'h2C);

    // 4: redirect and stall together, misaligned target
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    step();
    check("t4_pc", pc, 32'h40);
    check("t4_valid", {31'd0, if_id_valid}, 32'd0);
    check("t4_pc4", if_id_pc4, 32'h0);

    // 5: wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    check("t5_imem_top", imem_addr, 32'h3FFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("t5_pc_wrap", pc, 32'h0);
    check("t5_pc4_wrap", if_id_pc4, 32'h0);
    check("t5_cnt", fetch_count, 32'd5);

    // 6: reset mid-stream overrides stall and redirect
    step(); step();
    check("t6_cnt7", fetch_count, 32'd7);
    check("t6_valid", {31'd0, if_id_valid}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1234);
    step();
    check("t6_pc", pc, 32'h0);
    check("t6_valid0", {31'd0, if_id_valid}, 32'd0);
    check("t6_cnt0", fetch_count, 32'h0);

    // Random traffic, checked every cycle by the model compare process.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255))
                                        : $urandom_range(0, 255);
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), tgt);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
